// File: rtl/logic_reg_array_hs.sv
// logic_reg_array_hs: valid/ready register pipeline of skid or forward stages with a live occupancy count
module logic_reg_array_hs #(
  parameter int N_STAGES  = 2,
  parameter int DATA_BITS = 32,
  parameter bit SKID_MODE = 1'b1,
  parameter int CNT_BITS  = $clog2(2*N_STAGES+1)
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic [CNT_BITS-1:0]  occupancy
);
  logic                s_xfer, m_xfer;
  logic [CNT_BITS-1:0] occ_q, occ_d;
  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    logic                 in_vld, in_rdy, nxt_rdy, out_vld, in_xfer, out_xfer;
    logic [DATA_BITS-1:0] in_dat, out_dat;
    if (k == 0) begin : g_head
      assign in_vld = s_valid & ~areset;
      assign in_dat = s_data;
    end else begin : g_link
      assign in_vld = g_stage[k-1].out_vld;
      assign in_dat = g_stage[k-1].out_dat;
    end
    if (k == N_STAGES-1) begin : g_tail
      assign nxt_rdy = m_ready;
    end else begin : g_next
      assign nxt_rdy = g_stage[k+1].in_rdy;
    end
    assign in_xfer  = in_vld & in_rdy;
    assign out_xfer = out_vld & nxt_rdy;
    if (SKID_MODE) begin : g_skid
      logic                 mv_q, mv_d, kv_q, kv_d;
      logic [DATA_BITS-1:0] md_q, md_d, kd_q, kd_d;
      assign in_rdy  = ~kv_q;
      assign out_vld = mv_q;
      assign out_dat = md_q;
      // main refills from skid first, else from input; input parks in skid while main is stuck
      always_comb begin
        mv_d = mv_q;
        md_d = md_q;
        kv_d = kv_q;
        kd_d = kd_q;
        if (~mv_q | out_xfer) begin
          mv_d = kv_q | in_xfer;
          md_d = kv_q ? kd_q : in_dat;
          kv_d = 1'b0;
        end else if (in_xfer) begin
          kv_d = 1'b1;
          kd_d = in_dat;
        end
      end
      // valid flags reset, payload registers free-run
      always_ff @(posedge aclk) begin
        mv_q <= areset ? 1'b0 : mv_d;
        kv_q <= areset ? 1'b0 : kv_d;
        md_q <= md_d;
        kd_q <= kd_d;
      end
    end else begin : g_fwd
      logic                 mv_q, mv_d;
      logic [DATA_BITS-1:0] md_q, md_d;
      assign in_rdy  = ~mv_q | nxt_rdy;
      assign out_vld = mv_q;
      assign out_dat = md_q;
      // single register: load on input transfer, empty when drained without refill
      always_comb begin
        mv_d = in_xfer | (mv_q & ~out_xfer);
        md_d = in_xfer ? in_dat : md_q;
      end
      // valid flag resets, payload register free-runs
      always_ff @(posedge aclk) begin
        mv_q <= areset ? 1'b0 : mv_d;
        md_q <= md_d;
      end
    end
  end
  assign s_ready   = g_stage[0].in_rdy & ~areset;
  assign m_valid   = g_stage[N_STAGES-1].out_vld;
  assign m_data    = g_stage[N_STAGES-1].out_dat;
  assign s_xfer    = s_valid & s_ready;
  assign m_xfer    = m_valid & m_ready;
  assign occupancy = occ_q;
  // beats entering minus beats leaving; simultaneous in and out cancel
  always_comb begin
    occ_d = occ_q + CNT_BITS'(s_xfer) - CNT_BITS'(m_xfer);
  end
  // occupancy register cleared with the pipeline
  always_ff @(posedge aclk) begin
    occ_q <= areset ? '0 : occ_d;
  end
endmodule
